// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared types for the 5-stage pipeline hazard controller:
//            forwarding-select encoding, memory-wait FSM states and the
//            per-stage producer record.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  // Storage width for register addresses inside the stage records; the top
  // zero-extends its RADDR_W-wide addresses into this field.
  localparam int c_raddr_w_max = 16;

  // EX operand source encoding
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                     valid;
    logic [c_raddr_w_max-1:0] dst;
    logic                     wen;
    logic                     is_load;
  } stage_info_t;

  // A stage can supply a result when it holds a real, register-writing
  // instruction whose destination is not $0 and whose data is not still
  // outstanding (a load waiting on memory).
  function automatic logic can_produce(input stage_info_t s, input logic busy);
    return s.valid & s.wen & (s.dst != '0) & ~(s.is_load & busy);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_sel
// Brief    : Combinational forwarding comparator for one EX source operand.
//            The youngest matching producer (MEM) wins over WB.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                     i_ex_valid,
  input  logic [c_raddr_w_max-1:0] i_src,
  input  logic                     i_src_used,
  input  stage_info_t              i_mem,
  input  logic                     i_mem_wait,
  input  stage_info_t              i_wb,
  output logic [1:0]               o_fwd_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // Pick the operand source; register file unless a live producer matches.
  always_comb begin
    w_mem_hit = can_produce(i_mem, i_mem_wait) && (i_mem.dst == i_src);
    w_wb_hit  = can_produce(i_wb, 1'b0) && (i_wb.dst == i_src);
    o_fwd_sel = FWD_RF;
    if (i_ex_valid && i_src_used) begin
      if (w_mem_hit) begin
        o_fwd_sel = FWD_MEM;
      end else if (w_wb_hit) begin
        o_fwd_sel = FWD_WB;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline controller for the 5-stage MIPS datapath. Tracks the
//            EX/MEM/WB producers, generates load-use stalls, taken-branch
//            flushes, variable-latency memory freezes and EX forwarding
//            selects, and counts stall and flush events.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,   // must not exceed c_raddr_w_max
  parameter int MEM_LAT = 1    // 1..8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic [RADDR_W-1:0] id_dst,
  input  logic               id_wen,
  input  logic               id_is_load,
  input  logic               ex_taken,
  output logic               pc_hold,
  output logic               id_ex_bubble,
  output logic               flush_if_id,
  output logic               freeze,
  output logic [1:0]         fwd_a_sel,
  output logic [1:0]         fwd_b_sel,
  output logic               ex_valid,
  output logic               mem_valid,
  output logic               wb_valid,
  output logic               wb_wen,
  output logic [RADDR_W-1:0] wb_dst,
  output logic [XLEN-1:0]    stall_cycles,
  output logic [XLEN-1:0]    flush_count
);

  localparam int               c_cnt_w     = $clog2(MEM_LAT + 1);
  localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(MEM_LAT - 1);

  stage_info_t              ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [c_raddr_w_max-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic                     ex_uses_rs_q, ex_uses_rs_d;
  logic                     ex_uses_rt_q, ex_uses_rt_d;
  mem_state_e               state_q, state_d;
  logic [c_cnt_w-1:0]       wait_cnt_q, wait_cnt_d;
  logic [XLEN-1:0]          stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]          flush_cnt_q, flush_cnt_d;

  logic [c_raddr_w_max-1:0] w_id_rs, w_id_rt, w_id_dst;
  logic                     w_freeze;
  logic                     w_load_use;
  logic                     w_flush;
  logic                     w_bubble;
  logic                     w_pc_hold;

  // Hazard detection and the resulting hold/bubble/flush controls.
  always_comb begin
    w_id_rs    = c_raddr_w_max'(id_rs);
    w_id_rt    = c_raddr_w_max'(id_rt);
    w_id_dst   = c_raddr_w_max'(id_dst);
    w_freeze   = (state_q == ST_MEMWAIT);
    w_load_use = id_valid && ex_q.is_load && can_produce(ex_q, 1'b0) &&
                 ((id_uses_rs && (ex_q.dst == w_id_rs)) ||
                  (id_uses_rt && (ex_q.dst == w_id_rt)));
    // rst_n gates the flush so that a garbage ex_taken during reset cannot
    // surface as a control pulse; every other control derives from cleared
    // stage registers.
    w_flush    = ex_taken && !w_freeze && rst_n;
    w_bubble   = !w_freeze && (w_flush || w_load_use);
    w_pc_hold  = !w_freeze && !w_flush && w_load_use;
  end

  // Memory-wait FSM: a load entering MEM with MEM_LAT>1 freezes the
  // pipeline for MEM_LAT-1 cycles; the last freeze cycle returns to RUN.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if ((MEM_LAT > 1) && ex_q.valid && ex_q.is_load) begin
          state_d    = ST_MEMWAIT;
          wait_cnt_d = c_wait_load;
        end
      end
      ST_MEMWAIT: begin
        wait_cnt_d = wait_cnt_q - c_cnt_w'(1);
        if (wait_cnt_q == c_cnt_w'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Stage shift: all producer records advance unless frozen; a bubble or an
  // empty ID slot enters EX as an all-zero record.
  always_comb begin
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_uses_rs_d = ex_uses_rs_q;
    ex_uses_rt_d = ex_uses_rt_q;
    if (!w_freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (id_valid && !w_bubble) begin
        ex_d.valid   = 1'b1;
        ex_d.dst     = w_id_dst;
        ex_d.wen     = id_wen;
        ex_d.is_load = id_is_load;
        ex_rs_d      = w_id_rs;
        ex_rt_d      = w_id_rt;
        ex_uses_rs_d = id_uses_rs;
        ex_uses_rt_d = id_uses_rt;
      end else begin
        ex_d         = '0;
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        ex_uses_rs_d = 1'b0;
        ex_uses_rt_d = 1'b0;
      end
    end
  end

  // Performance counters: freeze cycles and uncancelled load-use stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_freeze || w_pc_hold) begin
      stall_cnt_d = stall_cnt_q + XLEN'(1);
    end
    if (w_flush) begin
      flush_cnt_d = flush_cnt_q + XLEN'(1);
    end
  end

  // State register for stage records, FSM and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_uses_rs_q <= 1'b0;
      ex_uses_rt_q <= 1'b0;
      state_q      <= ST_RUN;
      wait_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_uses_rs_q <= ex_uses_rs_d;
      ex_uses_rt_q <= ex_uses_rt_d;
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  hazard_fwd_sel u_fwd_a (
    .i_ex_valid (ex_q.valid),
    .i_src      (ex_rs_q),
    .i_src_used (ex_uses_rs_q),
    .i_mem      (mem_q),
    .i_mem_wait (w_freeze),
    .i_wb       (wb_q),
    .o_fwd_sel  (fwd_a_sel)
  );

  hazard_fwd_sel u_fwd_b (
    .i_ex_valid (ex_q.valid),
    .i_src      (ex_rt_q),
    .i_src_used (ex_uses_rt_q),
    .i_mem      (mem_q),
    .i_mem_wait (w_freeze),
    .i_wb       (wb_q),
    .o_fwd_sel  (fwd_b_sel)
  );

  assign pc_hold      = w_pc_hold;
  assign id_ex_bubble = w_bubble;
  assign flush_if_id  = w_flush;
  assign freeze       = w_freeze;
  assign ex_valid     = ex_q.valid;
  assign mem_valid    = mem_q.valid;
  assign wb_valid     = wb_q.valid;
  assign wb_wen       = wb_q.valid & wb_q.wen;
  assign wb_dst       = wb_q.dst[RADDR_W-1:0];
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench. Two controllers (MEM_LAT=1 and MEM_LAT=4)
//            share one ID/EX stimulus stream and are compared every cycle
//            against an instruction-level model; directed sequences add
//            hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_uses_rs, id_uses_rt, id_wen, id_is_load, ex_taken;
  logic [RW-1:0] id_rs, id_rt, id_dst;

  logic            pc_hold_o [2];
  logic            bubble_o  [2];
  logic            flush_o   [2];
  logic            freeze_o  [2];
  logic [1:0]      fa_o      [2];
  logic [1:0]      fb_o      [2];
  logic            exv_o     [2];
  logic            memv_o    [2];
  logic            wbv_o     [2];
  logic            wbwen_o   [2];
  logic [RW-1:0]   wbdst_o   [2];
  logic [XLEN-1:0] stall_o   [2];
  logic [XLEN-1:0] flushc_o  [2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(XLEN), .RADDR_W(RW), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_wen(id_wen), .id_is_load(id_is_load), .ex_taken(ex_taken),
    .pc_hold(pc_hold_o[0]), .id_ex_bubble(bubble_o[0]), .flush_if_id(flush_o[0]),
    .freeze(freeze_o[0]), .fwd_a_sel(fa_o[0]), .fwd_b_sel(fb_o[0]),
    .ex_valid(exv_o[0]), .mem_valid(memv_o[0]), .wb_valid(wbv_o[0]),
    .wb_wen(wbwen_o[0]), .wb_dst(wbdst_o[0]),
    .stall_cycles(stall_o[0]), .flush_count(flushc_o[0]));

  pipe_hazard_ctrl #(.XLEN(XLEN), .RADDR_W(RW), .MEM_LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_wen(id_wen), .id_is_load(id_is_load), .ex_taken(ex_taken),
    .pc_hold(pc_hold_o[1]), .id_ex_bubble(bubble_o[1]), .flush_if_id(flush_o[1]),
    .freeze(freeze_o[1]), .fwd_a_sel(fa_o[1]), .fwd_b_sel(fb_o[1]),
    .ex_valid(exv_o[1]), .mem_valid(memv_o[1]), .wb_valid(wbv_o[1]),
    .wb_wen(wbwen_o[1]), .wb_dst(wbdst_o[1]),
    .stall_cycles(stall_o[1]), .flush_count(flushc_o[1]));

  // ---------------- instruction-level reference model ----------------
  typedef struct {
    bit          valid;
    logic [RW-1:0] dst, rs, rt;
    bit          wen, ld, urs, urt;
  } ins_t;

  int            lat     [2];
  ins_t          m_ex    [2];
  ins_t          m_mem   [2];
  ins_t          m_wb    [2];
  int            m_age   [2];   // cycles the MEM occupant has spent in MEM
  bit [XLEN-1:0] m_stall [2];
  bit [XLEN-1:0] m_flush [2];

  bit       e_pc [2], e_bub [2], e_fl [2], e_frz [2];
  bit [1:0] e_fa [2], e_fb [2];

  int n_chk = 0;
  int n_err = 0;

  function automatic ins_t empty_ins();
    ins_t r;
    r.valid = 0; r.dst = '0; r.rs = '0; r.rt = '0;
    r.wen = 0; r.ld = 0; r.urs = 0; r.urt = 0;
    return r;
  endfunction

  function automatic bit produces(ins_t p, logic [RW-1:0] r, bit used);
    return used && p.valid && p.wen && (p.dst != '0) && (p.dst == r);
  endfunction

  function automatic bit [1:0] fwd(int k, logic [RW-1:0] r, bit used, bit frz);
    if (!m_ex[k].valid) return 2'd0;
    if (produces(m_mem[k], r, used) && !frz) return 2'd1;
    if (produces(m_wb[k], r, used)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = empty_ins(); m_mem[k] = empty_ins(); m_wb[k] = empty_ins();
      m_age[k] = 0; m_stall[k] = '0; m_flush[k] = '0;
    end
  endtask

  task automatic model_eval(int k);
    bit frz, lu, fl;
    frz = m_mem[k].valid && m_mem[k].ld && (m_age[k] < lat[k]);
    lu  = id_valid && m_ex[k].ld &&
          (produces(m_ex[k], id_rs, id_uses_rs) || produces(m_ex[k], id_rt, id_uses_rt));
    fl  = rst_n && ex_taken && !frz;
    e_frz[k] = frz;
    e_fl[k]  = fl;
    e_bub[k] = !frz && (fl || lu);
    e_pc[k]  = !frz && !fl && lu;
    e_fa[k]  = fwd(k, m_ex[k].rs, m_ex[k].urs, frz);
    e_fb[k]  = fwd(k, m_ex[k].rt, m_ex[k].urt, frz);
  endtask

  task automatic model_step(int k);
    ins_t n;
    model_eval(k);
    if (!rst_n) begin
      m_ex[k] = empty_ins(); m_mem[k] = empty_ins(); m_wb[k] = empty_ins();
      m_age[k] = 0; m_stall[k] = '0; m_flush[k] = '0;
    end else if (e_frz[k]) begin
      m_age[k]   = m_age[k] + 1;
      m_stall[k] = m_stall[k] + 32'd1;
    end else begin
      m_wb[k]  = m_mem[k];
      m_mem[k] = m_ex[k];
      m_age[k] = 1;
      n = empty_ins();
      if (id_valid && !e_bub[k]) begin
        n.valid = 1; n.dst = id_dst; n.rs = id_rs; n.rt = id_rt;
        n.wen = id_wen; n.ld = id_is_load; n.urs = id_uses_rs; n.urt = id_uses_rt;
      end
      m_ex[k] = n;
      if (e_pc[k]) m_stall[k] = m_stall[k] + 32'd1;
      if (e_fl[k]) m_flush[k] = m_flush[k] + 32'd1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [lat=%0d] t=%0t actual=%0h required=%0h", nm, lat[k], $time, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      model_eval(k);
      chk("pc_hold",      k, 64'(pc_hold_o[k]), 64'(e_pc[k]));
      chk("id_ex_bubble", k, 64'(bubble_o[k]),  64'(e_bub[k]));
      chk("flush_if_id",  k, 64'(flush_o[k]),   64'(e_fl[k]));
      chk("freeze",       k, 64'(freeze_o[k]),  64'(e_frz[k]));
      chk("fwd_a_sel",    k, 64'(fa_o[k]),      64'(e_fa[k]));
      chk("fwd_b_sel",    k, 64'(fb_o[k]),      64'(e_fb[k]));
      chk("ex_valid",     k, 64'(exv_o[k]),     64'(m_ex[k].valid));
      chk("mem_valid",    k, 64'(memv_o[k]),    64'(m_mem[k].valid));
      chk("wb_valid",     k, 64'(wbv_o[k]),     64'(m_wb[k].valid));
      chk("wb_wen",       k, 64'(wbwen_o[k]),   64'(m_wb[k].valid && m_wb[k].wen));
      chk("wb_dst",       k, 64'(wbdst_o[k]),   64'(m_wb[k].dst));
      chk("stall_cycles", k, 64'(stall_o[k]),   64'(m_stall[k]));
      chk("flush_count",  k, 64'(flushc_o[k]),  64'(m_flush[k]));
    end
  endtask

  // settle: sample away from the active edge; advance: clock edge + model
  task automatic settle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic set_id(bit v, logic [RW-1:0] rs, logic [RW-1:0] rt, bit urs, bit urt,
                        logic [RW-1:0] dst, bit wen, bit ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dst = dst; id_wen = wen; id_is_load = ld;
  endtask

  task automatic idle();
    set_id(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    ex_taken = 0;
  endtask

  task automatic rand_in();
    id_valid   = ($urandom_range(0, 3) != 0);
    id_rs      = RW'($urandom_range(0, 3));
    id_rt      = RW'($urandom_range(0, 3));
    id_uses_rs = 1'($urandom_range(0, 1));
    id_uses_rt = 1'($urandom_range(0, 1));
    id_dst     = RW'($urandom_range(0, 3));
    id_wen     = ($urandom_range(0, 3) != 0);
    id_is_load = ($urandom_range(0, 2) == 0);
    ex_taken   = ($urandom_range(0, 7) == 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    idle();
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic zero_lits(string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_pc_hold"}, k, 64'(pc_hold_o[k]), 64'd0);
      chk({tag, "_bubble"},  k, 64'(bubble_o[k]),  64'd0);
      chk({tag, "_flush"},   k, 64'(flush_o[k]),   64'd0);
      chk({tag, "_freeze"},  k, 64'(freeze_o[k]),  64'd0);
      chk({tag, "_valids"},  k, 64'({exv_o[k], memv_o[k], wbv_o[k], wbwen_o[k]}), 64'd0);
      chk({tag, "_wb_dst"},  k, 64'(wbdst_o[k]),   64'd0);
      chk({tag, "_counts"},  k, 64'({stall_o[k], flushc_o[k]}), 64'd0);
    end
  endtask

  initial begin
    lat[0] = 1;
    lat[1] = 4;
    rst_n  = 0;
    model_reset();
    idle();

    // Reset held across edges with random inputs
    for (int i = 0; i < 4; i++) begin
      rand_in();
      settle();
      zero_lits("reset");
      advance();
    end
    rst_n = 1;
    idle();
    settle();
    zero_lits("release");
    advance();

    // ALU back-to-back: MEM forwarding on A only
    do_reset();
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0); tick();
    set_id(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0); tick();
    idle(); settle();
    for (int k = 0; k < 2; k++) begin
      chk("alu_b2b_fwd_a", k, 64'(fa_o[k]), 64'd1);
      chk("alu_b2b_fwd_b", k, 64'(fb_o[k]), 64'd0);
    end
    advance();

    // One unrelated instruction in between: WB forwarding
    do_reset();
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0); tick();
    set_id(1, 5'd1, 5'd1, 0, 0, 5'd7, 1, 0); tick();
    set_id(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0); tick();
    idle(); settle();
    for (int k = 0; k < 2; k++) chk("alu_gap_fwd_a", k, 64'(fa_o[k]), 64'd2);
    advance();

    // Destination $0 never forwards
    do_reset();
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0); tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0); tick();
    idle(); settle();
    for (int k = 0; k < 2; k++) chk("dst0_fwd_a", k, 64'(fa_o[k]), 64'd0);
    advance();

    // Load-use: lw $2 ; add $6,$2,$2
    do_reset();
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd2, 1, 1); tick();
    set_id(1, 5'd2, 5'd2, 1, 1, 5'd6, 1, 0); settle();
    for (int k = 0; k < 2; k++) begin
      chk("ldu_pc_hold", k, 64'(pc_hold_o[k]), 64'd1);
      chk("ldu_bubble",  k, 64'(bubble_o[k]),  64'd1);
    end
    advance();
    settle();
    chk("ldu_pc_hold_once", 0, 64'(pc_hold_o[0]), 64'd0);
    chk("ldu_stall_cnt",    0, 64'(stall_o[0]),   64'd1);
    advance();
    idle(); settle();
    chk("ldu_fwd_a", 0, 64'(fa_o[0]), 64'd2);
    chk("ldu_fwd_b", 0, 64'(fb_o[0]), 64'd2);
    advance();

    // Flush beats load-use stall
    do_reset();
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd2, 1, 1); tick();
    set_id(1, 5'd2, 5'd0, 1, 0, 5'd6, 1, 0); ex_taken = 1; settle();
    for (int k = 0; k < 2; k++) begin
      chk("fos_flush",   k, 64'(flush_o[k]),   64'd1);
      chk("fos_bubble",  k, 64'(bubble_o[k]),  64'd1);
      chk("fos_pc_hold", k, 64'(pc_hold_o[k]), 64'd0);
    end
    advance();
    idle(); settle();
    for (int k = 0; k < 2; k++) begin
      chk("fos_flush_cnt", k, 64'(flushc_o[k]), 64'd1);
      chk("fos_stall_cnt", k, 64'(stall_o[k]),  64'd0);
    end
    advance();

    // Memory freeze, MEM_LAT=4: three freeze cycles, ex_taken deferred
    do_reset();
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd2, 1, 1); tick();
    idle(); settle();
    chk("frz_before", 1, 64'(freeze_o[1]), 64'd0);
    advance();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) ex_taken = 1;
      settle();
      chk("frz_active", 1, 64'(freeze_o[1]), 64'd1);
      chk("frz_flush_ignored", 1, 64'(flush_o[1]), 64'd0);
      advance();
    end
    settle();
    chk("frz_done",        1, 64'(freeze_o[1]), 64'd0);
    chk("frz_flush_later", 1, 64'(flush_o[1]),  64'd1);
    chk("frz_stall_cnt",   1, 64'(stall_o[1]),  64'd3);
    advance();
    ex_taken = 0; settle();
    chk("frz_flush_cnt", 1, 64'(flushc_o[1]), 64'd1);
    advance();

    // Reset asserted in the second freeze cycle
    do_reset();
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd2, 1, 1); tick();
    idle(); tick();
    tick();
    settle();
    chk("rmf_frz2", 1, 64'(freeze_o[1]), 64'd1);
    rst_n = 0;
    model_reset();
    #1;
    compare_all();
    chk("rmf_freeze",    1, 64'(freeze_o[1]), 64'd0);
    chk("rmf_mem_valid", 1, 64'(memv_o[1]),   64'd0);
    chk("rmf_stall_cnt", 1, 64'(stall_o[1]),  64'd0);
    advance();
    rst_n = 1;
    settle();
    chk("rmf_run", 1, 64'(freeze_o[1]), 64'd0);
    advance();

    // Randomised traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 0;
        model_reset();
      end else begin
        rst_n = 1;
      end
      rand_in();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
